prbs7_ber_ctrl: RTL and testbench
=================================

Name: prbs7_ber_ctrl

Overview:
Sequencer for a bit-error-rate run on the PRBS7 word checker in the ETROC2 readout test path. On start, it waits for the checker to report a run of consecutive error-free words (lock). It then counts checked words and erroneous words over a programmable window and reports done or lock-fail status. It consumes the checker's per-word error flag in the 40 MHz word-clock domain and drives status and counters to slow control.

Parameters:
LOCKLEN, 8, consecutive error-free words required to declare lock (1..255)
LOCKTIMEOUT, 255, maximum words spent in LOCK before declaring lock failure (must be > LOCKLEN, < 2^16)
WINWIDTH, 24, width of window length and word counter
ERRWIDTH, 16, width of saturating error counter

Ports:
clk  input  1  40 MHz word clock, rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  level sampled each edge; a high sample in IDLE/DONE/FAIL starts a run
abort  input  1  high sample returns to IDLE from any state; has priority over start
chk_error  input  1  per-word error flag from the PRBS7 checker, sampled each edge
cfg_window  input  WINWIDTH  words to count after lock; 0 = count until abort; sampled on start
busy  output  1  high in LOCK and COUNT
locked  output  1  high in COUNT and DONE
done  output  1  high in DONE
lock_fail  output  1  high in FAIL
err_count  output  ERRWIDTH  erroneous words counted in COUNT, saturating
word_count  output  WINWIDTH  words counted in COUNT

Behaviour:
- Reset: all outputs 0, state IDLE, internal lock_run/lock_timer/window register 0. Reset is asynchronous assert and synchronous-release use; it is legal mid-run and discards the run.
- All outputs are registered and decoded from state/counters; no combinational input-to-output paths.
- States: IDLE, LOCK, COUNT, DONE, FAIL.
- IDLE/DONE/FAIL + start=1, abort=0 at edge T -> LOCK at T. Clear err_count, word_count, lock_run, lock_timer. Latch cfg_window. busy=1, done=0, lock_fail=0, locked=0 after T.
- Start while in LOCK or COUNT is ignored.
- abort=1 in any state -> IDLE. Counters keep their values; done/locked/lock_fail/busy clear.
- LOCK, each edge:
  - lock_timer++.
  - chk_error=0: lock_run++. chk_error=1: lock_run=0.
  - If lock_run reaches LOCKLEN on this edge -> COUNT, locked=1. The first sample following lock is the first counted sample.
  - Otherwise, if lock_timer reaches LOCKTIMEOUT -> FAIL. Lock wins when both happen on the same edge.
- COUNT, each edge:
  - word_count++ (wraps only if cfg_window=0).
  - err_count += chk_error, saturating at 2^ERRWIDTH-1.
  - If cfg_window!=0 and the incremented word_count equals cfg_window -> DONE on the same edge.
- DONE and FAIL hold until start or abort.
- cfg_window changes during a run have no effect.

Test Plan:
- Reset: rstn low -> all outputs 0. Release, idle 10 cycles -> all outputs still 0.
- Clean run, defaults, cfg_window=100, chk_error=0: pulse start at edge T -> busy=1 after T; locked=1 after T+8; done=1, busy=0 after T+108; word_count=100, err_count=0.
- Errors in COUNT: same as the clean run plus chk_error=1 on 5 non-adjacent counted cycles -> done with err_count=5, word_count=100.
- Lock relock and timeout:
  - chk_error=1 on only the 5th LOCK sample -> locked after 13 LOCK samples.
  - chk_error held 1 -> lock_fail=1, busy=0 after exactly 255 LOCK samples.
  - A new start from FAIL clears lock_fail and re-enters LOCK.
- Saturation, ERRWIDTH=4, cfg_window=40, chk_error=1 throughout COUNT (clean during LOCK) -> err_count=15, word_count=40.
- Abort/reset/priority:
  - start during COUNT -> ignored, counting continues.
  - abort at counted word 30 -> IDLE, word_count=30 held, busy=0.
  - start and abort on the same edge in IDLE -> remains IDLE.
  - rstn low mid-COUNT -> immediate all-zero outputs.
  - cfg_window=0 -> never reaches done until abort.

Source files
------------

// File: rtl/prbs7_ber_ctrl.sv
// PRBS7 bit-error-rate run sequencer.
// Waits for a run of error-free words from the PRBS7 checker (lock), then
// counts checked and erroneous words over a programmable window.
module prbs7_ber_ctrl #(
  parameter int unsigned LOCKLEN     = 8,
  parameter int unsigned LOCKTIMEOUT = 255,
  parameter int unsigned WINWIDTH    = 24,
  parameter int unsigned ERRWIDTH    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic                chk_error,
  input  logic [WINWIDTH-1:0] cfg_window,
  output logic                busy,
  output logic                locked,
  output logic                done,
  output logic                lock_fail,
  output logic [ERRWIDTH-1:0] err_count,
  output logic [WINWIDTH-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCK,
    S_COUNT,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [7:0]  LOCKLEN_V = 8'(LOCKLEN);
  localparam logic [15:0] TIMEOUT_V = 16'(LOCKTIMEOUT);

  state_t              state, state_d;
  logic [7:0]          lock_run, lock_run_d;
  logic [15:0]         lock_timer, lock_timer_d;
  logic [WINWIDTH-1:0] window, window_d;
  logic [WINWIDTH-1:0] word_count_d;
  logic [ERRWIDTH-1:0] err_count_d;
  logic [7:0]          run_inc;
  logic [15:0]         timer_inc;

  // State register plus status flags decoded from the next state, so every
  // output leaves a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      locked    <= 1'b0;
      done      <= 1'b0;
      lock_fail <= 1'b0;
    end else begin
      state     <= state_d;
      busy      <= (state_d == S_LOCK) || (state_d == S_COUNT);
      locked    <= (state_d == S_COUNT) || (state_d == S_DONE);
      done      <= (state_d == S_DONE);
      lock_fail <= (state_d == S_FAIL);
    end
  end

  // Lock tracking, window latch and word/error counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_run   <= '0;
      lock_timer <= '0;
      window     <= '0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      lock_run   <= lock_run_d;
      lock_timer <= lock_timer_d;
      window     <= window_d;
      word_count <= word_count_d;
      err_count  <= err_count_d;
    end
  end

  // Next-state and counter update; abort outranks everything, and a lock
  // achieved on the timeout edge still counts as a lock.
  always_comb begin
    state_d      = state;
    lock_run_d   = lock_run;
    lock_timer_d = lock_timer;
    window_d     = window;
    word_count_d = word_count;
    err_count_d  = err_count;
    run_inc      = lock_run + 8'd1;
    timer_inc    = lock_timer + 16'd1;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_d      = S_LOCK;
            lock_run_d   = '0;
            lock_timer_d = '0;
            word_count_d = '0;
            err_count_d  = '0;
            window_d     = cfg_window;
          end
        end
        S_LOCK: begin
          lock_timer_d = timer_inc;
          lock_run_d   = chk_error ? '0 : run_inc;
          if (!chk_error && (run_inc == LOCKLEN_V)) begin
            state_d = S_COUNT;
          end else if (timer_inc == TIMEOUT_V) begin
            state_d = S_FAIL;
          end
        end
        S_COUNT: begin
          word_count_d = word_count + 1'b1;
          if (chk_error && (err_count != '1)) begin
            err_count_d = err_count + 1'b1;
          end
          if ((window != '0) && (word_count_d == window)) begin
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs7_ber_ctrl.sv
// Self-checking bench for prbs7_ber_ctrl: vector table, directed corner
// sequences and a randomized run against a flag-based behavioural model.
module tb_prbs7_ber_ctrl;

  localparam int unsigned LOCKLEN     = 8;
  localparam int unsigned LOCKTIMEOUT = 255;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        abort;
  logic        chk_error;
  logic [23:0] cfg_window;

  logic        busy, locked, done, lock_fail;
  logic [15:0] err_count;
  logic [23:0] word_count;

  logic        s_busy, s_locked, s_done, s_fail;
  logic [3:0]  s_err_count;
  logic [23:0] s_word_count;

  prbs7_ber_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .chk_error(chk_error), .cfg_window(cfg_window),
    .busy(busy), .locked(locked), .done(done), .lock_fail(lock_fail),
    .err_count(err_count), .word_count(word_count)
  );

  prbs7_ber_ctrl #(.ERRWIDTH(4)) dut_sat (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .chk_error(chk_error), .cfg_window(cfg_window),
    .busy(s_busy), .locked(s_locked), .done(s_done), .lock_fail(s_fail),
    .err_count(s_err_count), .word_count(s_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_flags(input string name, input bit b, input bit l, input bit d, input bit f);
    check({name, ".busy"},      32'(busy),      32'(b));
    check({name, ".locked"},    32'(locked),    32'(l));
    check({name, ".done"},      32'(done),      32'(d));
    check({name, ".lock_fail"}, 32'(lock_fail), 32'(f));
  endtask

  // Behavioural model: run status as flags, counts as plain integers.
  bit          m_busy, m_locked, m_done, m_fail;
  int unsigned m_run, m_timer, m_wc, m_ec, m_win;

  task automatic model_reset();
    m_busy = 0; m_locked = 0; m_done = 0; m_fail = 0;
    m_run = 0; m_timer = 0; m_wc = 0; m_ec = 0; m_win = 0;
  endtask

  task automatic model_step();
    if (abort) begin
      m_busy = 0; m_locked = 0; m_done = 0; m_fail = 0;
    end else if (!m_busy && start) begin
      m_busy = 1; m_locked = 0; m_done = 0; m_fail = 0;
      m_run = 0; m_timer = 0; m_wc = 0; m_ec = 0;
      m_win = int'(cfg_window);
    end else if (m_busy && !m_locked) begin
      m_timer++;
      m_run = chk_error ? 0 : m_run + 1;
      if (m_run == LOCKLEN) m_locked = 1;
      else if (m_timer == LOCKTIMEOUT) begin
        m_busy = 0; m_fail = 1;
      end
    end else if (m_busy) begin
      m_wc = (m_wc + 1) % (1 << 24);
      if (chk_error && m_ec < 65535) m_ec++;
      if (m_win != 0 && m_wc == m_win) begin
        m_busy = 0; m_done = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start_run(input logic [23:0] win);
    cfg_window = win;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  typedef struct {
    bit          st;
    bit          ab;
    bit          er;
    logic [23:0] win;
    bit          e_busy;
    bit          e_locked;
    bit          e_done;
    bit          e_fail;
    int unsigned e_wc;
    int unsigned e_ec;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, input bit ab, input bit er, input logic [23:0] win,
                     input bit b, input bit l, input bit d, input bit f,
                     input int unsigned wc, input int unsigned ec);
    vec_t v;
    v.st = st; v.ab = ab; v.er = er; v.win = win;
    v.e_busy = b; v.e_locked = l; v.e_done = d; v.e_fail = f;
    v.e_wc = wc; v.e_ec = ec;
    vecs.push_back(v);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; chk_error = 1'b0; cfg_window = '0;
    model_reset();

    // Reset state, then 10 idle cycles after release.
    #12;
    check_flags("reset", 0, 0, 0, 0);
    check("reset.wc", 32'(word_count), 0);
    check("reset.ec", 32'(err_count), 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) tick();
    check_flags("idle10", 0, 0, 0, 0);
    check("idle10.wc", 32'(word_count), 0);
    check("idle10.ec", 32'(err_count), 0);

    // Vector table: short window-3 run, abort/start priority, restart.
    add(1, 0, 0, 24'd3, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 0, 0, 24'd3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 24'd3, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 24'd3, 1, 1, 0, 0, 1, 1);
    add(0, 0, 0, 24'd3, 1, 1, 0, 0, 2, 1);
    add(0, 0, 1, 24'd3, 0, 1, 1, 0, 3, 2);
    add(0, 0, 0, 24'd3, 0, 1, 1, 0, 3, 2);
    add(1, 1, 0, 24'd3, 0, 0, 0, 0, 3, 2);
    add(1, 0, 1, 24'd0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; abort = vecs[i].ab;
      chk_error = vecs[i].er; cfg_window = vecs[i].win;
      tick();
      check_flags($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_locked,
                  vecs[i].e_done, vecs[i].e_fail);
      check($sformatf("vec%0d.wc", i), 32'(word_count), vecs[i].e_wc);
      check($sformatf("vec%0d.ec", i), 32'(err_count), vecs[i].e_ec);
    end
    start = 1'b0; chk_error = 1'b0;
    do_abort();

    // Clean run, window 100: lock exactly 8 edges after start, done 100 later.
    start_run(24'd100);
    check_flags("clean.T", 1, 0, 0, 0);
    repeat (7) tick();
    check("clean.T7.locked", 32'(locked), 0);
    tick();
    check_flags("clean.T8", 1, 1, 0, 0);
    repeat (99) tick();
    check("clean.T107.done", 32'(done), 0);
    tick();
    check_flags("clean.T108", 0, 1, 1, 0);
    check("clean.wc", 32'(word_count), 100);
    check("clean.ec", 32'(err_count), 0);

    // Five isolated errors during COUNT.
    start_run(24'd100);
    repeat (8) tick();
    for (int i = 1; i <= 100; i++) begin
      chk_error = (i % 10 == 0) && (i <= 50);
      tick();
    end
    chk_error = 1'b0;
    check_flags("errs", 0, 1, 1, 0);
    check("errs.wc", 32'(word_count), 100);
    check("errs.ec", 32'(err_count), 5);

    // Error on the 5th LOCK sample restarts the run: lock on sample 13.
    start_run(24'd100);
    for (int i = 1; i <= 12; i++) begin
      chk_error = (i == 5);
      tick();
    end
    chk_error = 1'b0;
    check("relock.s12.locked", 32'(locked), 0);
    tick();
    check("relock.s13.locked", 32'(locked), 1);
    do_abort();

    // Persistent errors: lock failure on exactly the 255th sample.
    chk_error = 1'b1;
    start_run(24'd100);
    repeat (254) tick();
    check_flags("tmo.s254", 1, 0, 0, 0);
    tick();
    check_flags("tmo.s255", 0, 0, 0, 1);
    chk_error = 1'b0;
    start_run(24'd100);
    check_flags("tmo.restart", 1, 0, 0, 0);
    do_abort();

    // Saturating 4-bit error counter over a 40-word window.
    start_run(24'd40);
    repeat (8) tick();
    chk_error = 1'b1;
    repeat (40) tick();
    chk_error = 1'b0;
    check("sat.ec", 32'(s_err_count), 15);
    check("sat.wc", 32'(s_word_count), 40);
    check("sat.busy", 32'(s_busy), 0);
    check("sat.locked", 32'(s_locked), 1);
    check("sat.done", 32'(s_done), 1);
    check("sat.fail", 32'(s_fail), 0);
    check("sat.main_ec", 32'(err_count), 40);

    // Start during COUNT ignored; abort after counted word 30 holds counts.
    start_run(24'd100);
    repeat (8) tick();
    for (int i = 1; i <= 30; i++) begin
      start = (i >= 5) && (i <= 10);
      tick();
    end
    start = 1'b0;
    check_flags("ign.w30", 1, 1, 0, 0);
    check("ign.wc", 32'(word_count), 30);
    do_abort();
    check_flags("abort", 0, 0, 0, 0);
    check("abort.wc", 32'(word_count), 30);

    // start and abort together in IDLE stays in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_flags("st_ab", 0, 0, 0, 0);
    check("st_ab.wc", 32'(word_count), 30);

    // Window 0 counts until abort.
    start_run(24'd0);
    repeat (308) tick();
    check_flags("win0", 1, 1, 0, 0);
    check("win0.wc", 32'(word_count), 300);
    do_abort();
    check_flags("win0.abort", 0, 0, 0, 0);
    check("win0.abort.wc", 32'(word_count), 300);

    // Reset asserted mid-COUNT clears outputs without a clock edge.
    start_run(24'd50);
    repeat (20) tick();
    chk_error = 1'b1;
    tick();
    chk_error = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    check_flags("rst_mid", 0, 0, 0, 0);
    check("rst_mid.wc", 32'(word_count), 0);
    check("rst_mid.ec", 32'(err_count), 0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic against the model.
    begin
      int unsigned rate;
      rate = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 500 == 0) begin
          case ($urandom_range(0, 3))
            0: rate = 0;
            1: rate = 5;
            2: rate = 30;
            default: rate = 100;
          endcase
        end
        start      = ($urandom_range(0, 19) == 0);
        abort      = ($urandom_range(0, 299) == 0);
        chk_error  = ($urandom_range(0, 99) < rate);
        cfg_window = 24'($urandom_range(0, 30));
        tick();
        check_flags($sformatf("rnd%0d", c), m_busy, m_locked, m_done, m_fail);
        check($sformatf("rnd%0d.wc", c), 32'(word_count), m_wc);
        check($sformatf("rnd%0d.ec", c), 32'(err_count), m_ec);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
